candy_sram_arbiter: RTL and testbench

- Two-requester front end for the single-port candy SRAM. It shares the SRAM between the instruction-fetch port (read only) and the data-memory port (read/write).
- Serialises requests into one-cycle SRAM read or write strobes. Never asserts SRAM read and write together.
- Returns read data and a one-cycle ack to the winning requester.
- A timeout watchdog ends any read whose ready pulse never arrives.

---
 rtl/candy_sram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_candy_sram_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/candy_sram_arbiter.sv
// Two-requester (fetch / data) arbiter for the single-port candy SRAM with read timeout.
// Optional macro CANDY_SRAM_ARB_RR_EN selects round-robin instead of mem-over-if priority.
module candy_sram_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output logic              busy,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_re,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_rdata_ready
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_DONE} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              is_wr_q, is_wr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_waddr_q, sram_waddr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic              sram_re_q, sram_re_d;
  logic [ADDR_W-1:0] sram_raddr_q, sram_raddr_d;

  logic              grant_mem;
  logic              ack_now;
  logic              rd_load;
  logic [DATA_W-1:0] rd_value;

  // owner_q keeps the last winner while IDLE, so it also serves as last_grant.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    is_wr_d      = is_wr_q;
    cnt_d        = cnt_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    err_d        = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    sram_we_d    = 1'b0;
    sram_waddr_d = '0;
    sram_wdata_d = '0;
    sram_re_d    = 1'b0;
    sram_raddr_d = '0;
    ack_now      = 1'b0;
    rd_load      = 1'b0;
    rd_value     = '0;

`ifdef CANDY_SRAM_ARB_RR_EN
    if (mem_req && if_req) begin
      grant_mem = (owner_q == OWN_IF);
    end else begin
      grant_mem = mem_req;
    end
`else
    grant_mem = mem_req;
`endif

    case (state_q)
      S_IDLE: begin
        if (mem_req || if_req) begin
          state_d = S_CMD;
          owner_d = grant_mem ? OWN_MEM : OWN_IF;
          is_wr_d = grant_mem && mem_we;
          if (is_wr_d) begin
            sram_we_d    = 1'b1;
            sram_waddr_d = mem_addr;
            sram_wdata_d = mem_wdata;
          end else begin
            sram_re_d    = 1'b1;
            sram_raddr_d = grant_mem ? mem_addr : if_addr;
          end
        end
      end
      S_CMD: begin
        if (is_wr_q) begin
          state_d = S_DONE;
          ack_now = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (sram_rdata_ready) begin
          state_d  = S_DONE;
          ack_now  = 1'b1;
          rd_load  = 1'b1;
          rd_value = sram_rdata;
        end else if (cnt_q == TO_LAST) begin
          state_d  = S_DONE;
          ack_now  = 1'b1;
          rd_load  = 1'b1;
          rd_value = '1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (ack_now) begin
      if (owner_q == OWN_MEM) begin
        mem_ack_d = 1'b1;
        if (rd_load) mem_rdata_d = rd_value;
      end else begin
        if_ack_d = 1'b1;
        if (rd_load) if_rdata_d = rd_value;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      is_wr_q      <= 1'b0;
      cnt_q        <= '0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_waddr_q <= '0;
      sram_wdata_q <= '0;
      sram_re_q    <= 1'b0;
      sram_raddr_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      is_wr_q      <= is_wr_d;
      cnt_q        <= cnt_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      sram_we_q    <= sram_we_d;
      sram_waddr_q <= sram_waddr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_re_q    <= sram_re_d;
      sram_raddr_q <= sram_raddr_d;
    end
  end

  assign if_ack     = if_ack_q;
  assign if_rdata   = if_rdata_q;
  assign mem_ack    = mem_ack_q;
  assign mem_rdata  = mem_rdata_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign sram_we    = sram_we_q;
  assign sram_waddr = sram_waddr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_re    = sram_re_q;
  assign sram_raddr = sram_raddr_q;

endmodule

// File: tb/tb_candy_sram_arbiter.sv
// Directed bench for candy_sram_arbiter with a behavioural SRAM whose read-ready delay is programmable.
// Build with CANDY_SRAM_ARB_RR_EN to expect round-robin grants in the contention step.
module tb_candy_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [9:0]  if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [9:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;
  logic        busy;
  logic        sram_we;
  logic [9:0]  sram_waddr;
  logic [31:0] sram_wdata;
  logic        sram_re;
  logic [9:0]  sram_raddr;
  logic [31:0] sram_rdata = '0;
  logic        sram_rdata_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int ready_delay = 0;

  candy_sram_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_ack           (if_ack),
    .if_rdata         (if_rdata),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .err              (err),
    .busy             (busy),
    .sram_we          (sram_we),
    .sram_waddr       (sram_waddr),
    .sram_wdata       (sram_wdata),
    .sram_re          (sram_re),
    .sram_raddr       (sram_raddr),
    .sram_rdata       (sram_rdata),
    .sram_rdata_ready (sram_rdata_ready)
  );

  always #5 clk = ~clk;

  // SRAM model: word i powers up as 0xA5000000|i; ready follows the read strobe after ready_delay cycles.
  logic [31:0] sram_mem [0:1023];
  logic        rd_pend = 1'b0;
  int          rd_cnt = 0;
  logic [9:0]  rd_addr = '0;

  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = 32'hA500_0000 | 32'(i);
  end

  always @(posedge clk) begin
    sram_rdata_ready <= 1'b0;
    if (sram_we) sram_mem[sram_waddr] <= sram_wdata;
    if (sram_re) begin
      if (ready_delay == 0) begin
        sram_rdata_ready <= 1'b1;
        sram_rdata       <= sram_mem[sram_raddr];
        rd_pend          <= 1'b0;
      end else begin
        rd_pend <= 1'b1;
        rd_cnt  <= ready_delay - 1;
        rd_addr <= sram_raddr;
      end
    end else if (rd_pend) begin
      if (rd_cnt == 0) begin
        sram_rdata_ready <= 1'b1;
        sram_rdata       <= sram_mem[rd_addr];
        rd_pend          <= 1'b0;
      end else begin
        rd_cnt <= rd_cnt - 1;
      end
    end
  end

  // Protocol watch over every cycle: exclusive strobes, single-cycle strobes, no ack without a req.
  logic prev_we = 1'b0;
  logic prev_re = 1'b0;
  logic if_armed = 1'b0;
  logic mem_armed = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_we   <= 1'b0;
      prev_re   <= 1'b0;
      if_armed  <= 1'b0;
      mem_armed <= 1'b0;
    end else begin
      if (sram_we && sram_re) begin
        viol <= viol + 1;
        $display("[TB] invariant violation at %0t: sram_we and sram_re together", $time);
      end
      if ((sram_we && prev_we) || (sram_re && prev_re)) begin
        viol <= viol + 1;
        $display("[TB] invariant violation at %0t: strobe high two cycles", $time);
      end
      if ((if_ack && !if_armed) || (mem_ack && !mem_armed)) begin
        viol <= viol + 1;
        $display("[TB] invariant violation at %0t: ack without request", $time);
      end
      prev_we <= sram_we;
      prev_re <= sram_re;
      if (if_ack) if_armed <= 1'b0;
      if (if_req) if_armed <= 1'b1;
      if (mem_ack) mem_armed <= 1'b0;
      if (mem_req) mem_armed <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int n_mem;
  int n_if;
  int stray;
  logic [3:0] seq;
  logic [3:0] exp_seq;
  int exp_n_if;

  initial begin
    $display("[TB] start");
    // Reset state
    repeat (3) tick();
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_strobes", 64'({sram_we, sram_re, if_ack, mem_ack, err}), 64'd0);
    check_output("rst_rdata", 64'({if_rdata, mem_rdata}), 64'd0);
    rst = 1'b1;
    tick();

    // mem write 0x05 <- 0xDEADBEEF; ack sampled two edges after the grant edge
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 10'h005; mem_wdata = 32'hDEAD_BEEF;
    tick();
    check_output("wr_cmd_we", 64'(sram_we), 64'd1);
    check_output("wr_cmd_re", 64'(sram_re), 64'd0);
    check_output("wr_cmd_waddr", 64'(sram_waddr), 64'h005);
    check_output("wr_cmd_wdata", 64'(sram_wdata), 64'hDEAD_BEEF);
    check_output("wr_cmd_busy", 64'(busy), 64'd1);
    check_output("wr_cmd_ack", 64'(mem_ack), 64'd0);
    tick();
    check_output("wr_done_ack", 64'({mem_ack, if_ack, err}), 64'b100);
    check_output("wr_done_we", 64'(sram_we), 64'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    check_output("wr_idle", 64'({mem_ack, busy}), 64'd0);

    // fetch read of 0x05 returns written data, ack three edges after grant
    if_req = 1'b1; if_addr = 10'h005;
    tick();
    check_output("rd_cmd_re", 64'({sram_re, sram_we}), 64'b10);
    check_output("rd_cmd_raddr", 64'(sram_raddr), 64'h005);
    tick();
    check_output("rd_wait_ack", 64'({if_ack, sram_re}), 64'd0);
    tick();
    check_output("rd_done_ack", 64'({if_ack, mem_ack, err}), 64'b100);
    check_output("rd_done_data", 64'(if_rdata), 64'hDEAD_BEEF);
    if_req = 1'b0;
    tick();
    check_output("rd_hold_data", 64'({if_ack, if_rdata}), 64'hDEAD_BEEF);

    // timed-out fetch read: ready arrives 20 cycles late, ack+err ten edges after grant
    ready_delay = 20;
    if_req = 1'b1; if_addr = 10'h007;
    tick();
    check_output("to_cmd_re", 64'(sram_re), 64'd1);
    repeat (8) tick();
    check_output("to_before_ack", 64'({if_ack, busy}), 64'b01);
    tick();
    check_output("to_ack_err", 64'({if_ack, err}), 64'b11);
    check_output("to_rdata", 64'(if_rdata), 64'hFFFF_FFFF);
    if_req = 1'b0;
    tick();
    check_output("to_err_clear", 64'({if_ack, err}), 64'd0);
    stray = 0;
    repeat (20) begin
      tick();
      if (if_ack || mem_ack || busy) stray++;
    end
    check_output("late_ready_ignored", 64'(stray), 64'd0);

    // normal read afterwards has err low
    ready_delay = 0;
    if_req = 1'b1; if_addr = 10'h007;
    repeat (3) tick();
    check_output("rd2_ack_err", 64'({if_ack, err}), 64'b10);
    check_output("rd2_data", 64'(if_rdata), 64'hA500_0007);
    if_req = 1'b0;
    tick();

    // both requesters held high: fixed priority starves fetch, round-robin alternates
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h010;
    if_req = 1'b1; if_addr = 10'h020;
    seq = '0; n_mem = 0; n_if = 0;
    repeat (16) begin
      tick();
      if (mem_ack) begin n_mem++; seq = {seq[2:0], 1'b1}; end
      if (if_ack) begin n_if++; seq = {seq[2:0], 1'b0}; end
    end
    mem_req = 1'b0; if_req = 1'b0;
`ifdef CANDY_SRAM_ARB_RR_EN
    exp_seq = 4'b1010; exp_n_if = 2;
`else
    exp_seq = 4'b1111; exp_n_if = 0;
`endif
    check_output("tie_order", 64'(seq), 64'(exp_seq));
    check_output("tie_total", 64'(n_mem + n_if), 64'd4);
    check_output("tie_if_grants", 64'(n_if), 64'(exp_n_if));
    check_output("tie_mem_rdata", 64'(mem_rdata), 64'hA500_0010);
    tick();
    check_output("tie_idle", 64'(busy), 64'd0);

    // reset asserted during a read CMD cycle
    if_req = 1'b1; if_addr = 10'h003;
    tick();
    check_output("rr_cmd_re", 64'(sram_re), 64'd1);
    rst = 1'b0;
    #1;
    check_output("rr_outputs_zero", 64'({sram_re, sram_we, busy, if_ack, mem_ack, err}), 64'd0);
    check_output("rr_addr_zero", 64'({sram_raddr, sram_waddr}), 64'd0);
    check_output("rr_rdata_zero", 64'({if_rdata, mem_rdata}), 64'd0);
    if_req = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    stray = 0;
    repeat (10) begin
      tick();
      if (if_ack || mem_ack || busy) stray++;
    end
    check_output("rr_no_ack", 64'(stray), 64'd0);

    check_output("invariants", 64'(viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
